// File: rtl/max_stream_reducer_if.sv
// Handshake bundle for max_stream_reducer: operand stream in, frame result out.
// The slave modport is the reducer's view; master is the source/sink environment.
interface max_stream_reducer_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_max;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W:0]   m_len;
    logic             m_ovf;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_max, m_idx, m_len, m_ovf
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_max, m_idx, m_len, m_ovf
    );
endinterface

// File: rtl/max_stream_reducer.sv
// Reduces each last-framed operand stream to (max, first index of max, length),
// closing early at MAX_LEN, with a single registered result slot.
module max_stream_reducer #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter bit SIGNED  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    max_stream_reducer_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;
    localparam logic [IDX_W:0] LEN_LIMIT = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] CNT_ONE   = (IDX_W+1)'(1);

    logic [0:0]       state;
    logic [WIDTH-1:0] acc_max, nxt_max;
    logic [IDX_W-1:0] acc_idx, nxt_idx;
    logic [IDX_W:0]   acc_cnt, nxt_cnt;
    logic             accept, greater, at_limit, close;

    assign bus.s_ready = ~bus.m_valid | bus.m_ready;
    assign accept      = bus.s_valid & bus.s_ready;

    always_comb begin
        if (SIGNED)
            greater = $signed(bus.s_data) > $signed(acc_max);
        else
            greater = bus.s_data > acc_max;
    end

    // Strict compare so ties keep the earlier index; the current count is the new beat's index.
    always_comb begin
        nxt_max = acc_max;
        nxt_idx = acc_idx;
        nxt_cnt = acc_cnt + CNT_ONE;
        if (state == IDLE) begin
            nxt_max = bus.s_data;
            nxt_idx = '0;
            nxt_cnt = CNT_ONE;
        end else if (greater) begin
            nxt_max = bus.s_data;
            nxt_idx = acc_cnt[IDX_W-1:0];
        end
    end

    assign at_limit = (nxt_cnt == LEN_LIMIT);
    assign close    = accept & (bus.s_last | at_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc_max <= '0;
            acc_idx <= '0;
            acc_cnt <= '0;
        end else if (accept) begin
            acc_max <= nxt_max;
            acc_idx <= nxt_idx;
            acc_cnt <= nxt_cnt;
            state   <= close ? IDLE : ACCUM;
        end
    end

    // A close can only happen when the slot is empty or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_valid <= 1'b0;
            bus.m_max   <= '0;
            bus.m_idx   <= '0;
            bus.m_len   <= '0;
            bus.m_ovf   <= 1'b0;
        end else if (close) begin
            bus.m_valid <= 1'b1;
            bus.m_max   <= nxt_max;
            bus.m_idx   <= nxt_idx;
            bus.m_len   <= nxt_cnt;
            bus.m_ovf   <= at_limit & ~bus.s_last;
        end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_max_stream_reducer.sv
// Directed and randomized bench for max_stream_reducer with a queue-based result scoreboard.
module tb_max_stream_reducer;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;

    typedef struct {
        logic [7:0] max;
        logic [3:0] idx;
        logic [4:0] len;
        logic       ovf;
    } result_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   rand_mode = 0;

    result_t exp_q[$];
    int         mcnt = 0;
    logic [7:0] mmax = '0;
    logic [3:0] midx = '0;

    max_stream_reducer_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();
    max_stream_reducer_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus_s ();

    max_stream_reducer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .SIGNED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    max_stream_reducer #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the unsigned reducer; pushes a result whenever a frame closes.
    task automatic model_beat(input logic [7:0] d, input logic last);
        result_t r;
        if (mcnt == 0) begin
            mmax = d;
            midx = '0;
        end else if (d > mmax) begin
            mmax = d;
            midx = 4'(mcnt);
        end
        mcnt++;
        if (last || mcnt == MAX_LEN) begin
            r.max = mmax;
            r.idx = midx;
            r.len = 5'(mcnt);
            r.ovf = (mcnt == MAX_LEN) && !last;
            exp_q.push_back(r);
            mcnt = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last);
        int  waited = 0;
        bit  done = 0;
        bit  taken = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!done) begin
            @(negedge clk);
            if (bus.s_ready) begin
                done  = 1;
                taken = 1;
            end else if (waited++ > 200) begin
                done = 1;
                checks++;
                failures++;
                $error("[TB] FAIL accept_timeout observed=stalled expected=accepted");
            end
            @(posedge clk);
            #1;
            if (rand_mode) bus.m_ready = ($urandom_range(0, 3) != 0);
        end
        if (taken) model_beat(d, last);
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        bus.m_ready = 1'b1;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        bus_s.s_valid = 1'b0; bus_s.s_data = '0; bus_s.s_last = 1'b0; bus_s.m_ready = 1'b1;

        // Result monitor: a handshake seen at the negedge completes on the next posedge.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("[TB] FAIL unexpected_result observed=%0h expected=none", bus.m_max);
                    end else begin
                        result_t r;
                        r = exp_q.pop_front();
                        checkOutput("res_max", 32'(bus.m_max), 32'(r.max));
                        checkOutput("res_idx", 32'(bus.m_idx), 32'(r.idx));
                        checkOutput("res_len", 32'(bus.m_len), 32'(r.len));
                        checkOutput("res_ovf", 32'(bus.m_ovf), 32'(r.ovf));
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("rst_m_max",   32'(bus.m_max),   32'd0);
        checkOutput("rst_m_idx",   32'(bus.m_idx),   32'd0);
        checkOutput("rst_m_len",   32'(bus.m_len),   32'd0);
        checkOutput("rst_m_ovf",   32'(bus.m_ovf),   32'd0);
        checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] frame 3,9,4,9");
        applyStimulus(8'd3, 1'b0);
        applyStimulus(8'd9, 1'b0);
        applyStimulus(8'd4, 1'b0);
        applyStimulus(8'd9, 1'b1);
        checkOutput("latency_m_valid", 32'(bus.m_valid), 32'd1);
        drain();

        $display("[TB] back-to-back single-beat frames");
        applyStimulus(8'h7F, 1'b1);
        applyStimulus(8'h80, 1'b1);
        drain();

        $display("[TB] signed frame 0x80,0x7F");
        bus_s.s_valid = 1'b1; bus_s.s_data = 8'h80; bus_s.s_last = 1'b0;
        @(posedge clk); #1;
        bus_s.s_data = 8'h7F; bus_s.s_last = 1'b1;
        @(posedge clk); #1;
        bus_s.s_valid = 1'b0;
        checkOutput("signed_m_valid", 32'(bus_s.m_valid), 32'd1);
        checkOutput("signed_m_max",   32'(bus_s.m_max),   32'h7F);
        checkOutput("signed_m_idx",   32'(bus_s.m_idx),   32'd1);
        checkOutput("signed_m_len",   32'(bus_s.m_len),   32'd2);

        $display("[TB] 17 beats, overflow at MAX_LEN");
        for (int k = 0; k <= 16; k++) applyStimulus(8'(k), k == 16);
        drain();

        $display("[TB] output stall");
        bus.m_ready = 1'b0;
        applyStimulus(8'd1, 1'b0);
        applyStimulus(8'd2, 1'b1);
        bus.s_valid = 1'b1; bus.s_data = 8'd7; bus.s_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_s_ready", 32'(bus.s_ready), 32'd0);
            checkOutput("stall_m_valid", 32'(bus.m_valid), 32'd1);
            checkOutput("stall_m_max",   32'(bus.m_max),   32'd2);
            checkOutput("stall_m_len",   32'(bus.m_len),   32'd2);
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b1;
        #1;
        checkOutput("unstall_s_ready", 32'(bus.s_ready), 32'd1);
        applyStimulus(8'd7, 1'b0);
        applyStimulus(8'd8, 1'b1);
        drain();

        $display("[TB] reset mid-frame");
        applyStimulus(8'd5, 1'b0);
        applyStimulus(8'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        mcnt  = 0;
        #1;
        checkOutput("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("midrst_m_max",   32'(bus.m_max),   32'd0);
        checkOutput("midrst_m_len",   32'(bus.m_len),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'd1, 1'b1);
        drain();

        $display("[TB] random frames");
        rand_mode = 1;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    bus.m_ready = ($urandom_range(0, 3) != 0);
                end
                applyStimulus(8'($urandom_range(0, 255)), b == len - 1);
            end
        end
        rand_mode = 0;
        drain();
        checkOutput("final_m_valid", 32'(bus.m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
